count_pwm_gen: RTL and testbench

Downstream consumer of the N-bit free-running counter: samples its `count` bus, detects period wrap and compare match, and drives a PWM output whose duty value is loaded through a valid/ready handshake. New duty values are double-buffered and take effect only at a wrap boundary, so each counter period is glitch-free. Sits directly after the counter in the timer/PWM path and shares its clock and clear.

---
 rtl/count_pkg.sv | 13 +
 rtl/count_deadband.sv | 39 +++
 rtl/count_pwm_gen.sv | 114 +++++++++++
 tb/tb_count_pwm_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared definitions for the counter and its downstream PWM generator.
//   COUNT_N_DEF  - default counter MSB index (counter and duty buses are N+1 bits)
//   duty_state_e - duty double-buffer handshake state
package count_pkg;

    localparam int unsigned COUNT_N_DEF = 7;

    typedef enum logic {
        StEmpty   = 1'b0,
        StPending = 1'b1
    } duty_state_e;

endpackage

// File: rtl/count_deadband.sv
// count_deadband: complementary output stage with a one-cycle dead band.
// Only compiled when COUNT_PWM_DEADBAND_EN is defined.
// Ports:
//   clock   in  system clock, rising edge
//   clear   in  synchronous active-high reset
//   pwm_raw in  unregistered compare result
//   pwm     out high only after pwm_raw has been high for two consecutive cycles
//   pwm_n   out high only after pwm_raw has been low for two consecutive cycles
`ifdef COUNT_PWM_DEADBAND_EN
module count_deadband (
    input  logic clock,
    input  logic clear,
    input  logic pwm_raw,
    output logic pwm,
    output logic pwm_n
);

    logic pwm_raw_q;
    logic pwm_q;
    logic pwm_n_q;

    // ANDing with the delayed copy forces both outputs low for one cycle at each edge
    always_ff @(posedge clock) begin
        if (clear) begin
            pwm_raw_q <= 1'b0;
            pwm_q     <= 1'b0;
            pwm_n_q   <= 1'b0;
        end else begin
            pwm_raw_q <= pwm_raw;
            pwm_q     <= pwm_raw & pwm_raw_q;
            pwm_n_q   <= ~pwm_raw & ~pwm_raw_q;
        end
    end

    assign pwm   = pwm_q;
    assign pwm_n = pwm_n_q;

endmodule
`endif

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: PWM generator fed by a free-running N+1 bit counter.
// Detects period wrap and compare match; duty values arrive over valid/ready and are
// double-buffered so they only take effect at a wrap.
// Optional feature macro: COUNT_PWM_DEADBAND_EN adds pwm_n and a dead-band output stage.
// Ports:
//   clock      in  system clock, rising edge
//   clear      in  synchronous active-high reset (shared with the counter)
//   count      in  counter value
//   duty_data  in  requested compare value
//   duty_valid in  duty_data valid
//   duty_ready out can accept a new duty value (registered)
//   pwm        out PWM output (registered)
//   wrap       out one-cycle pulse, new period started
//   match      out one-cycle pulse, count equalled active duty
//   pwm_n      out complementary output (COUNT_PWM_DEADBAND_EN only)
module count_pwm_gen
    import count_pkg::*;
#(
    parameter int unsigned N = COUNT_N_DEF
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [N:0] count,
    input  logic [N:0] duty_data,
    input  logic       duty_valid,
    output logic       duty_ready,
`ifdef COUNT_PWM_DEADBAND_EN
    output logic       pwm_n,
`endif
    output logic       pwm,
    output logic       wrap,
    output logic       match
);

    duty_state_e state_q, state_d;
    logic [N:0]  prev_count_q;
    logic [N:0]  active_duty_q, active_duty_d;
    logic [N:0]  pending_duty_q, pending_duty_d;
    logic        ready_q;
    logic        wrap_q, match_q;
    logic        wrap_d, match_d, pwm_raw;

    always_comb begin
        // A drop in count is a rollover or an external counter clear
        wrap_d         = count < prev_count_q;
        pwm_raw        = count < active_duty_q;
        match_d        = count == active_duty_q;
        state_d        = state_q;
        active_duty_d  = active_duty_q;
        pending_duty_d = pending_duty_q;
        unique case (state_q)
            StEmpty: begin
                if (duty_valid && ready_q) begin
                    pending_duty_d = duty_data;
                    state_d        = StPending;
                end
            end
            StPending: begin
                if (wrap_d) begin
                    active_duty_d = pending_duty_q;
                    state_d       = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q        <= StEmpty;
            prev_count_q   <= '0;
            active_duty_q  <= '0;
            pending_duty_q <= '0;
            ready_q        <= 1'b0;
            wrap_q         <= 1'b0;
            match_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_count_q   <= count;
            active_duty_q  <= active_duty_d;
            pending_duty_q <= pending_duty_d;
            ready_q        <= state_d == StEmpty;
            wrap_q         <= wrap_d;
            match_q        <= match_d;
        end
    end

`ifdef COUNT_PWM_DEADBAND_EN
    count_deadband u_deadband (
        .clock   (clock),
        .clear   (clear),
        .pwm_raw (pwm_raw),
        .pwm     (pwm),
        .pwm_n   (pwm_n)
    );
`else
    logic pwm_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_raw;
        end
    end

    assign pwm = pwm_q;
`endif

    assign duty_ready = ready_q;
    assign wrap       = wrap_q;
    assign match      = match_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// tb_count_pwm_gen: randomized + directed bench for count_pwm_gen (N=7).
// The bench plays the role of the counter and keeps a reference model of the duty queue.
module tb_count_pwm_gen;

    localparam int unsigned N = 7;

    logic       clock = 1'b0;
    logic       clear;
    logic [N:0] count;
    logic [N:0] duty_data;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm;
    logic       wrap;
    logic       match;
`ifdef COUNT_PWM_DEADBAND_EN
    logic       pwm_n;
`endif

    count_pwm_gen #(.N(N)) dut (
        .clock      (clock),
        .clear      (clear),
        .count      (count),
        .duty_data  (duty_data),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
`ifdef COUNT_PWM_DEADBAND_EN
        .pwm_n      (pwm_n),
`endif
        .pwm        (pwm),
        .wrap       (wrap),
        .match      (match)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: active duty plus a queue of at most one waiting value
    int m_prev = 0;
    int m_active = 0;
    int pend_q[$];
    bit m_ready = 1'b0;
    bit e_pwm, e_wrap, e_match, e_pwm_n;
    bit raw_prev = 1'b0;
    bit accepted;
    int used_duty;
    int c_edge;

    // Per-period on-time bookkeeping
    int hi = 0;
    int per_duty = 0;
    bit per_ok = 1'b0;

    function automatic int exp_high(input int d);
`ifdef COUNT_PWM_DEADBAND_EN
        return (d == 0) ? 0 : d - 1;
`else
        return d;
`endif
    endfunction

    task automatic model_edge();
        int c;
        bit raw;
        bit w;
        c = int'(count);
        c_edge = c;
        accepted = 1'b0;
        if (clear) begin
            m_prev = 0;
            m_active = 0;
            pend_q.delete();
            m_ready = 1'b0;
            e_pwm = 1'b0;
            e_pwm_n = 1'b0;
            e_wrap = 1'b0;
            e_match = 1'b0;
            raw_prev = 1'b0;
            used_duty = -1;
        end else begin
            w = c < m_prev;
            raw = c < m_active;
            e_wrap = w;
            e_match = (c == m_active);
            used_duty = m_active;
`ifdef COUNT_PWM_DEADBAND_EN
            e_pwm = raw && raw_prev;
            e_pwm_n = !raw && !raw_prev;
            raw_prev = raw;
`else
            e_pwm = raw;
`endif
            // A value already waiting is applied at the wrap; one accepted now waits
            if (w && pend_q.size() > 0) m_active = pend_q.pop_front();
            if (duty_valid && m_ready) begin
                pend_q.push_back(int'(duty_data));
                accepted = 1'b1;
            end
            m_ready = (pend_q.size() == 0);
            m_prev = c;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("pwm", 32'(pwm), 32'(e_pwm));
        check("wrap", 32'(wrap), 32'(e_wrap));
        check("match", 32'(match), 32'(e_match));
        check("duty_ready", 32'(duty_ready), 32'(m_ready));
`ifdef COUNT_PWM_DEADBAND_EN
        check("pwm_n", 32'(pwm_n), 32'(e_pwm_n));
        check("both_high", 32'(pwm & pwm_n), 32'd0);
`endif
        if (used_duty < 0) begin
            per_ok = 1'b0;
        end else begin
            if (c_edge == 0) begin
                hi = 0;
                per_duty = used_duty;
                per_ok = 1'b1;
            end else if (used_duty != per_duty) begin
                per_ok = 1'b0;
            end
            hi += int'(pwm);
            if (c_edge == 255 && per_ok) check("period_high", 32'(hi), 32'(exp_high(per_duty)));
        end
        // Counter shares the clock and the clear
        count = clear ? '0 : count + 8'd1;
        if (!duty_valid) duty_data = 8'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 600 && int'(count) != v; i++) tick();
    endtask

    task automatic load(input int v);
        bit got;
        got = 1'b0;
        duty_valid = 1'b1;
        duty_data = 8'(v);
        for (int i = 0; i < 1000 && !got; i++) begin
            tick();
            got = accepted;
        end
        duty_valid = 1'b0;
        if (!got) check("load_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int total_hi;
        int r;
        clear = 1'b1;
        count = '0;
        duty_data = '0;
        duty_valid = 1'b0;

        // Reset held for three cycles, then a full period at duty 0
        run(3);
        clear = 1'b0;
        run(300);

        // Duty 64 loaded before the wrap
        load(64);
        run(256 * 3);

        // Double buffer: 192 mid-period, second attempt while pending is ignored
        wait_cnt(100);
        load(192);
        duty_valid = 1'b1;
        duty_data = 8'd50;
        run(20);
        duty_valid = 1'b0;
        run(600);

        // Accept exactly in the count=0 (wrap) cycle
        wait_cnt(0);
        duty_valid = 1'b1;
        duty_data = 8'd10;
        tick();
        duty_valid = 1'b0;
        run(600);

        // Mid-period clear with 128 active and 200 pending
        load(128);
        run(600);
        wait_cnt(90);
        load(200);
        wait_cnt(100);
        clear = 1'b1;
        run(2);
        clear = 1'b0;
        total_hi = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            total_hi += int'(pwm);
        end
        check("pwm_after_clear", 32'(total_hi), 32'd0);

        // Boundaries
        load(0);
        run(600);
        load(255);
        run(600);

        // Random loads, occasional clears and counter jumps
        for (int i = 0; i < 4000; i++) begin
            if (!duty_valid && $urandom_range(0, 99) < 4) begin
                duty_valid = 1'b1;
                duty_data = 8'($urandom);
            end
            r = int'($urandom_range(0, 999));
            clear = (r < 3);
            tick();
            if (accepted) duty_valid = 1'b0;
            if (r >= 3 && r < 6) begin
                count = 8'($urandom);
                per_ok = 1'b0;
            end
        end
        clear = 1'b0;
        duty_valid = 1'b0;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
